alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
// - Producer side of the 4-bit ALU operation bus: decodes the main-control ALUOp
//   plus funct3/funct7[5] into the ALU operation code and registers it into EX.
// - Registered decode stage between ID and EX with a valid/ready handshake,
//   flush, and a multi-cycle hold for the multiply/shift (4'b0100) operation.
// PARAMETERS
// - MUL_LAT  3  EX cycles an op 4'b0100 needs (>=1); 1 = no extra hold
// PORTS
// - clk         in   1  clock, rising edge
// - reset       in   1  asynchronous reset, active-high
// - in_valid    in   1  ID presents a decoded instruction
// - in_ready    out  1  stage can accept this cycle
// - alu_op_in   in   2  ALUOp: 00 load/store, 01 branch, 10 R-type, 11 I-type
// - funct3      in   3  instr[14:12]
// - funct7_5    in   1  instr[30]
// - flush       in   1  kill held/incoming op (branch taken)
// - out_valid   out  1  alu_ctrl valid for EX
// - out_ready   in   1  EX consumes alu_ctrl this cycle
// - alu_ctrl    out  4  ALU op: 0000 and, 0001 or, 0010 add, 0110 sub, 0100 mul/slli, 1100 nor
// - illegal     out  1  registered with alu_ctrl; unsupported encoding
// BEHAVIOUR
// - Reset (async): state IDLE, out_valid=0, alu_ctrl=4'b0010, illegal=0, cnt=0.
// - Decode: 00->0010; 01->0110; 10: f3=000 -> f7_5?0110:0010, 111->0000, 110->0001,
//   001->0100; 11: 000->0010, 111->0000, 110->0001, 001->0100.
//   Any other combination -> alu_ctrl=0010, illegal=1.
// - States: IDLE (nothing held), WAIT (op held, cnt>0, out_valid=0),
//   VALID (op held, out_valid=1).
// - in_ready = (state==IDLE) | (state==VALID & out_ready); combinational, not
//   dependent on in_valid. Accept = in_valid & in_ready & ~flush.
// - Accept, op!=0100 or MUL_LAT==1: next cycle alu_ctrl/illegal loaded, state VALID.
// - Accept, op==0100, MUL_LAT>1: alu_ctrl loaded, cnt=MUL_LAT-1, state WAIT;
//   cnt decrements each cycle; at cnt==1 next state VALID (out_valid rises
//   exactly MUL_LAT cycles after accept edge).
// - VALID & out_ready & no accept -> IDLE, out_valid=0; alu_ctrl/illegal hold last value.
// - VALID & out_ready & accept same cycle: back-to-back, no bubble.
// - VALID & ~out_ready: alu_ctrl/illegal/out_valid stable until consumed.
// - flush (any state): next cycle state IDLE, out_valid=0, cnt=0; flush beats
//   a same-cycle accept (input dropped); alu_ctrl/illegal hold value.
// - WAIT ignores out_ready; in_ready=0 throughout WAIT.
// - reset mid-WAIT: immediate return to reset values; no op emitted.
// CONFIGURATION
// - ALU_CTRL_NOR_EN defined: ALUOp=10, funct3=100, funct7_5=1 -> 1100 (nor), illegal=0.
// - Not defined: that encoding -> 0010, illegal=1; 1100 never produced.
// TESTING
// - reset asserted mid-run -> out_valid=0, alu_ctrl=0010, illegal=0, in_ready=1.
// - ALUOp=10,f3=000,f7_5=1, out_ready=1 -> cycle+1 out_valid=1, alu_ctrl=0110.
// - ALUOp=11,f3=001, MUL_LAT=3 -> out_valid 0,0 then 1 on 3rd edge, alu_ctrl=0100,
//   in_ready=0 during WAIT.
// - Stream 00,01,10/111 with out_ready=1 -> 0010,0110,0000 on consecutive cycles;
//   then out_ready=0 for 2 cycles -> 0000 held, in_ready=0.
// - flush with in_valid=1 in VALID -> next cycle out_valid=0, input not emitted.
// - ALUOp=10,f3=100,f7_5=1 -> 1100/illegal=0 with ALU_CTRL_NOR_EN, else 0010/illegal=1.

Source files
------------

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: registered ALU-control decode stage between ID and EX.
// Decodes ALUOp/funct3/funct7[5] into the 4-bit ALU operation code and
// presents it to EX through a valid/ready handshake. Multiply/shift ops
// (4'b0100) are held for MUL_LAT cycles before being offered.
// Optional feature macro: ALU_CTRL_NOR_EN (enables R-type funct3=100,
// funct7[5]=1 as the NOR operation 4'b1100).
module alu_ctrl_issue #(
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] alu_op_in,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0100;
`ifdef ALU_CTRL_NOR_EN
  localparam logic [3:0] OP_NOR = 4'b1100;
`endif

  // Counter only needs to hold MUL_LAT-1; keep at least one bit.
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit HOLD_MUL = (MUL_LAT > 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    VALID = 2'b10
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    dec_op;
  logic          dec_ill;
  logic          accept;
  logic          load;
  logic          go_wait;

  // Combinational decode of the incoming instruction fields.
  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    unique case (alu_op_in)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        unique case (funct3)
          3'b000:  dec_op = funct7_5 ? OP_SUB : OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b001:  dec_op = OP_MUL;
`ifdef ALU_CTRL_NOR_EN
          3'b100: begin
            if (funct7_5) begin
              dec_op = OP_NOR;
            end else begin
              dec_ill = 1'b1;
            end
          end
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      2'b11: begin
        unique case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b001:  dec_op = OP_MUL;
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign in_ready  = (state == IDLE) || ((state == VALID) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign go_wait   = HOLD_MUL && (dec_op == OP_MUL);
  assign out_valid = (state == VALID);

  // Next-state and hold-counter logic; flush overrides everything.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (accept) begin
      load = 1'b1;
      if (go_wait) begin
        state_n = WAIT;
        cnt_n   = CNT_LOAD;
      end else begin
        state_n = VALID;
        cnt_n   = '0;
      end
    end else begin
      unique case (state)
        IDLE: state_n = IDLE;
        VALID: begin
          if (out_ready) begin
            state_n = IDLE;
          end
        end
        WAIT: begin
          if (cnt <= CNT_ONE) begin
            state_n = VALID;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CNT_ONE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State register and hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Output operation register, loaded only when an instruction is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_ctrl <= OP_ADD;
      illegal  <= 1'b0;
    end else if (load) begin
      alu_ctrl <= dec_op;
      illegal  <= dec_ill;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: directed self-checking bench for alu_ctrl_issue (MUL_LAT=3).
// Honors ALU_CTRL_NOR_EN for the NOR-encoding expectation.
module tb_alu_ctrl_issue;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op_in;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       illegal;

  int total_checks;
  int fail_checks;

  alu_ctrl_issue #(.MUL_LAT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op_in (alu_op_in),
    .funct3    (funct3),
    .funct7_5  (funct7_5),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [2:0] f3,
                               input logic f7, input logic fl, input logic ordy);
    in_valid  = v;
    alu_op_in = op;
    funct3    = f3;
    funct7_5  = f7;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic [3:0] ec,
                             input logic ei, input logic er);
    #1;
    total_checks++;
    assert (out_valid === ev) else begin
      fail_checks++;
      $error("[TB] FAIL %s out_valid=%0b expected %0b", tag, out_valid, ev);
    end
    total_checks++;
    assert (alu_ctrl === ec) else begin
      fail_checks++;
      $error("[TB] FAIL %s alu_ctrl=%04b expected %04b", tag, alu_ctrl, ec);
    end
    total_checks++;
    assert (illegal === ei) else begin
      fail_checks++;
      $error("[TB] FAIL %s illegal=%0b expected %0b", tag, illegal, ei);
    end
    total_checks++;
    assert (in_ready === er) else begin
      fail_checks++;
      $error("[TB] FAIL %s in_ready=%0b expected %0b", tag, in_ready, er);
    end
  endtask

  initial begin
    logic [3:0] nor_ctrl;
    logic       nor_ill;
`ifdef ALU_CTRL_NOR_EN
    nor_ctrl = 4'b1100;
    nor_ill  = 1'b0;
`else
    nor_ctrl = 4'b0010;
    nor_ill  = 1'b1;
`endif
    total_checks = 0;
    fail_checks  = 0;
    reset = 1'b1;
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset", 1'b0, 4'b0010, 1'b0, 1'b1);
    reset = 1'b0;

    // R-type sub, single cycle
    applyStimulus(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("sub_valid_stall", 1'b1, 4'b0110, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("sub_valid_ready", 1'b1, 4'b0110, 1'b0, 1'b1);
    tick();
    checkOutput("sub_consumed", 1'b0, 4'b0110, 1'b0, 1'b1);

    // I-type slli: multi-cycle hold, offered op during WAIT must be ignored
    applyStimulus(1'b1, 2'b11, 3'b001, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("mul_wait1", 1'b0, 4'b0100, 1'b0, 1'b0);
    tick();
    checkOutput("mul_wait2", 1'b0, 4'b0100, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("mul_valid", 1'b1, 4'b0100, 1'b0, 1'b1);
    tick();
    checkOutput("mul_consumed", 1'b0, 4'b0100, 1'b0, 1'b1);

    // Back-to-back stream, then EX stalls
    applyStimulus(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("stream_ld", 1'b1, 4'b0010, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 1'b1);
    checkOutput("stream_br", 1'b1, 4'b0110, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_and", 1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("stall1", 1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("stall2", 1'b1, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("stall_drain", 1'b0, 4'b0000, 1'b0, 1'b1);

    // Flush in VALID with a same-cycle incoming op
    applyStimulus(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b10, 3'b110, 1'b0, 1'b1, 1'b1);
    checkOutput("pre_flush", 1'b1, 4'b0010, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_valid", 1'b0, 4'b0010, 1'b0, 1'b1);

    // Flush during WAIT: the held op is never emitted
    applyStimulus(1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_wait_pre", 1'b0, 4'b0100, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_wait1", 1'b0, 4'b0100, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("flush_wait3", 1'b0, 4'b0100, 1'b0, 1'b1);

    // Illegal I-type encoding, then NOR encoding back-to-back
    applyStimulus(1'b1, 2'b11, 3'b010, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
    checkOutput("illegal_itype", 1'b1, 4'b0010, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("nor_enc", 1'b1, nor_ctrl, nor_ill, 1'b1);
    tick();
    checkOutput("nor_consumed", 1'b0, nor_ctrl, nor_ill, 1'b1);

    // Asynchronous reset in the middle of WAIT
    applyStimulus(1'b1, 2'b11, 3'b001, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_wait_pre", 1'b0, 4'b0100, 1'b0, 1'b0);
    reset = 1'b1;
    checkOutput("rst_async", 1'b0, 4'b0010, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    tick();
    checkOutput("rst_no_emit", 1'b0, 4'b0010, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
    $finish;
  end

endmodule
